// File: rtl/aes_mix_columns.sv
// AES MixColumns stage: mixes COLS_PER_CYCLE columns per clock under a valid/ready handshake.
// Define AES_INV_MIX_EN to add the i_inverse port and InvMixColumns datapath.
module aes_mix_columns #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [0:127] i_data,
    input  logic         i_bypass,
`ifdef AES_INV_MIX_EN
    input  logic         i_inverse,
`endif
    output logic         o_valid,
    input  logic         i_ready,
    output logic [0:127] o_data,
    output logic         o_busy
);

    localparam int N = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [1:0]   r_cnt;
    logic [0:127] r_work;
    logic [0:127] w_work_mixed;
    logic         r_bypass;
`ifdef AES_INV_MIX_EN
    logic         r_inverse;
`endif

    logic [COLS_PER_CYCLE-1:0][31:0] w_lane_in;
    logic [COLS_PER_CYCLE-1:0][31:0] w_lane_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of a column sits in bits [31-8r -: 8] (row 0 is the most significant byte).
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [3:0][7:0] a;
        logic [31:0]     res;
        res = '0;
        for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                             ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return res;
    endfunction

`ifdef AES_INV_MIX_EN
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [3:0][7:0] a;
        logic [3:0][7:0] m9;
        logic [3:0][7:0] mb;
        logic [3:0][7:0] md;
        logic [3:0][7:0] me;
        logic [7:0]      x2;
        logic [7:0]      x4;
        logic [7:0]      x8;
        logic [31:0]     res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return res;
    endfunction
`endif

    // One mixing lane per column handled in a cycle; bypass outranks inverse.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign w_lane_in[g] = r_work[32*(int'(r_cnt)*COLS_PER_CYCLE + g) +: 32];
`ifdef AES_INV_MIX_EN
        assign w_lane_out[g] = r_bypass  ? w_lane_in[g] :
                               r_inverse ? mix_inv(w_lane_in[g]) :
                                           mix_fwd(w_lane_in[g]);
`else
        assign w_lane_out[g] = r_bypass ? w_lane_in[g] : mix_fwd(w_lane_in[g]);
`endif
    end

    always_comb begin
        w_work_mixed = r_work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            w_work_mixed[32*(int'(r_cnt)*COLS_PER_CYCLE + g) +: 32] = w_lane_out[g];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_next_state = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next_state = S_DONE;
            S_DONE:  if (i_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == S_IDLE) & i_reset_n;
        o_valid = (r_state == S_DONE);
        o_busy  = (r_state != S_IDLE);
        o_data  = (r_state == S_DONE) ? r_work : '0;
    end

    // Reset drops any half-mixed block along with the control state.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_bypass  <= 1'b0;
`ifdef AES_INV_MIX_EN
            r_inverse <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_work    <= i_data;
                        r_bypass  <= i_bypass;
`ifdef AES_INV_MIX_EN
                        r_inverse <= i_inverse;
`endif
                        r_cnt     <= '0;
                    end
                end
                S_RUN: begin
                    r_work <= w_work_mixed;
                    r_cnt  <= (r_cnt == LAST) ? 2'd0 : r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mix_columns.sv
// Bench for aes_mix_columns: known-answer table, backpressure, mid-run reset and random back-to-back traffic.
module tb_aes_mix_columns;

    localparam int COLS = 1;
    localparam int N    = 4 / COLS;

    logic         i_clock;
    logic         i_reset_n;
    logic         i_valid;
    logic         o_ready;
    logic [0:127] i_data;
    logic         i_bypass;
    logic         tb_inv;
    logic         o_valid;
    logic         i_ready;
    logic [0:127] o_data;
    logic         o_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    aes_mix_columns #(.COLS_PER_CYCLE(COLS)) dut (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_bypass (i_bypass),
`ifdef AES_INV_MIX_EN
        .i_inverse(tb_inv),
`endif
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_busy   (o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;
    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        logic [0:127] din;
        logic         byp;
        logic [0:127] exp;
    } vec_t;

    // Reference: plain GF(2^8) matrix product over each column.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int r, input int k, input logic inv);
        int idx;
        idx = (k - r + 4) % 4;
        case (idx)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [0:127] model(input logic [0:127] d, input logic byp, input logic inv);
        logic [0:127] res;
        logic [7:0]   acc;
        if (byp) return d;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef(r, k, inv), d[8*(4*c+k) +: 8]);
                res[8*(4*c+r) +: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic chk128(input string name, input logic [0:127] act, input logic [0:127] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(output logic ok);
        int w;
        w = 0;
        @(negedge i_clock);
        while (!o_ready && w < 50) begin
            @(negedge i_clock);
            w++;
        end
        ok = o_ready;
        if (!ok) chk("wait_ready_timeout", 0, 1);
    endtask

    // Accept one block, then count edges until o_valid rises.
    task automatic send(input logic [0:127] d, input logic byp, input logic inv, output int lat);
        logic ok;
        lat = -1;
        wait_ready(ok);
        if (!ok) return;
        i_valid  = 1'b1;
        i_data   = d;
        i_bypass = byp;
        tb_inv   = inv;
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 50) begin
            @(posedge i_clock);
            #1;
            lat++;
        end
        if (!o_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        @(negedge i_clock);
        i_ready = 1'b1;
        @(posedge i_clock);
        #1;
        i_ready = 1'b0;
        chk("drained_valid", int'(o_valid), 0);
    endtask

    localparam logic [0:127] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [0:127] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    vec_t         tbl[4];
    int           lat;
    logic [0:127] held;
    logic [0:127] rv;
    logic         rb;
    logic         ok;
    int           acc_cyc[8];

    initial begin
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_bypass  = 1'b0;
        tb_inv    = 1'b0;
        i_ready   = 1'b0;

        tbl[0] = '{FIPS_IN, 1'b0, FIPS_OUT};
        tbl[1] = '{FIPS_IN, 1'b1, FIPS_IN};
        tbl[2] = '{128'hd4d4d4d5_2d26314c_db135345_f20a225c, 1'b0,
                   128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d};
        tbl[3] = '{128'h00000000_ffffffff_80808080_01020304, 1'b1,
                   128'h00000000_ffffffff_80808080_01020304};

        repeat (3) @(negedge i_clock);
        chk("rst_valid", int'(o_valid), 0);
        chk128("rst_data", o_data, '0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ready_held", int'(o_ready), 0);
        i_reset_n = 1'b1;
        #1;
        chk("rst_ready_released", int'(o_ready), 1);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].din, tbl[i].byp, 1'b0, lat);
            chk($sformatf("tbl%0d_latency", i), lat, N);
            chk128($sformatf("tbl%0d_data", i), o_data, tbl[i].exp);
            chk128($sformatf("tbl%0d_model", i), o_data, model(tbl[i].din, tbl[i].byp, 1'b0));
            drain();
        end

        // Backpressure: result must hold and a second request must be ignored.
        send(FIPS_IN, 1'b0, 1'b0, lat);
        held = o_data;
        chk128("bp_first", held, FIPS_OUT);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clock);
            i_valid = 1'b1;
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            chk($sformatf("bp_valid%0d", i), int'(o_valid), 1);
            chk($sformatf("bp_ready%0d", i), int'(o_ready), 0);
            chk128($sformatf("bp_data%0d", i), o_data, FIPS_OUT);
        end
        @(negedge i_clock);
        i_valid = 1'b0;
        drain();
        @(negedge i_clock);
        chk("bp_idle_busy", int'(o_busy), 0);
        chk("bp_idle_ready", int'(o_ready), 1);

        // Reset during the second RUN cycle.
        wait_ready(ok);
        i_valid  = 1'b1;
        i_data   = FIPS_IN;
        i_bypass = 1'b0;
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
        @(posedge i_clock);
        #1;
        chk("mid_busy_before", int'(o_busy), 1);
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk128("mid_rst_data", o_data, '0);
        chk("mid_rst_busy", int'(o_busy), 0);
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;
        #1;
        chk("mid_rst_ready", int'(o_ready), 1);
        send(FIPS_IN, 1'b0, 1'b0, lat);
        chk("mid_repeat_latency", lat, N);
        chk128("mid_repeat_data", o_data, FIPS_OUT);
        drain();

`ifdef AES_INV_MIX_EN
        send(FIPS_OUT, 1'b0, 1'b1, lat);
        chk("inv_latency", lat, N);
        chk128("inv_data", o_data, FIPS_IN);
        drain();
        send(FIPS_OUT, 1'b1, 1'b1, lat);
        chk128("inv_bypass_prio", o_data, FIPS_OUT);
        drain();
`endif

        // Back-to-back random traffic with both handshakes tied high.
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_ready(ok);
            rv = {$urandom, $urandom, $urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0);
            i_data     = rv;
            i_bypass   = rb;
            tb_inv     = 1'b0;
            acc_cyc[i] = cyc;
            @(posedge i_clock);
            #1;
            lat = 0;
            while (!o_valid && lat < 50) begin
                @(posedge i_clock);
                #1;
                lat++;
            end
            chk($sformatf("b2b%0d_latency", i), lat, N);
            chk128($sformatf("b2b%0d_data", i), o_data, model(rv, rb, 1'b0));
            if (i > 0) chk($sformatf("b2b%0d_period", i), acc_cyc[i] - acc_cyc[i-1], N + 2);
        end
        i_valid = 1'b0;
        repeat (2) @(negedge i_clock);
        chk("b2b_final_busy", int'(o_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
